// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester front end for a shared combinational ALU.
// One operation in flight at a time: IDLE grants, EXEC drives the ALU for a
// cycle, RESP holds the captured result until the consumer takes it.
module alu_arbiter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [2:0]       req0_op,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [2:0]       req1_op,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_control,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_zero,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_zero,
   output logic             rsp_err,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t           state, state_nxt;
   logic             last_gnt;   // requester granted most recently
   logic             gnt_any;
   logic             gnt_id;
   logic [WIDTH-1:0] opa, opb;
   logic [2:0]       ctl;        // already mapped to a legal ALU code
   logic             ill;
   logic             op_id;
   logic [2:0]       sel_op;

   function automatic logic op_legal(input logic [2:0] op);
      return (op == 3'b000) || (op == 3'b001) || (op == 3'b010) ||
             (op == 3'b110) || (op == 3'b111);
   endfunction

   assign alu_a       = opa;
   assign alu_b       = opb;
   assign alu_control = ctl;
   assign rsp_valid   = (state == RESP);
   assign busy        = (state != IDLE);
   assign sel_op      = gnt_id ? req1_op : req0_op;

   // Next-state, grant and ready decode; readies only ever rise in IDLE.
   always_comb begin
      state_nxt  = state;
      gnt_any    = 1'b0;
      gnt_id     = 1'b0;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      case (state)
         IDLE: begin
            gnt_any    = req0_valid | req1_valid;
            gnt_id     = (req0_valid && req1_valid) ? ~last_gnt : req1_valid;
            req0_ready = gnt_any & ~gnt_id;
            req1_ready = gnt_any & gnt_id;
            if (gnt_any) state_nxt = EXEC;
         end
         EXEC:    state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Operand registers load only on acceptance; illegal codes run as add.
   always_ff @(posedge clk) begin
      if (reset) begin
         opa   <= '0;
         opb   <= '0;
         ctl   <= 3'b010;
         ill   <= 1'b0;
         op_id <= 1'b0;
      end else if (gnt_any) begin
         opa   <= gnt_id ? req1_a : req0_a;
         opb   <= gnt_id ? req1_b : req0_b;
         ctl   <= op_legal(sel_op) ? sel_op : 3'b010;
         ill   <= ~op_legal(sel_op);
         op_id <= gnt_id;
      end
   end

   // Response capture at the end of EXEC; held through RESP.
   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_result <= '0;
         rsp_zero   <= 1'b0;
         rsp_err    <= 1'b0;
         rsp_id     <= 1'b0;
      end else if (state == EXEC) begin
         rsp_result <= ill ? '0 : alu_result;
         rsp_zero   <= ill ? 1'b1 : alu_zero;
         rsp_err    <= ill;
         rsp_id     <= op_id;
      end
   end

   // Round-robin pointer moves on the response handshake; reset value of 1
   // makes requester 0 win the first contention.
   always_ff @(posedge clk) begin
      if (reset)                           last_gnt <= 1'b1;
      else if (state == RESP && rsp_ready) last_gnt <= rsp_id;
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed + randomized transactions against a transaction-
// level model (grant prediction, expected ALU outcome, latency).
module tb_alu_arbiter;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset;
   logic         req0_valid, req1_valid;
   logic         req0_ready, req1_ready;
   logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
   logic [2:0]   req0_op, req1_op;
   logic [W-1:0] alu_a, alu_b, alu_result;
   logic [2:0]   alu_control;
   logic         alu_zero;
   logic         rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err, busy;
   logic [W-1:0] rsp_result;

   int tests = 0;
   int fails = 0;
   bit exp_prio;   // requester expected to win the next contention

   always #5 clk = ~clk;

   alu_arbiter #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
      .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
      .alu_result(alu_result), .alu_zero(alu_zero),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
      .busy(busy)
   );

   // Shared combinational ALU sitting outside the arbiter.
   always_comb begin
      alu_result = '0;
      case (alu_control)
         3'b000: alu_result = alu_a & alu_b;
         3'b001: alu_result = alu_a | alu_b;
         3'b010: alu_result = alu_a + alu_b;
         3'b110: alu_result = alu_a - alu_b;
         3'b111: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
         default: alu_result = '0;
      endcase
      alu_zero = (alu_result == '0);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   // Expected response for an operation: {err, zero, result}.
   function automatic logic [33:0] model(input logic [31:0] a, b, input logic [2:0] op);
      longint r;
      case (op)
         3'b000: r = a & b;
         3'b001: r = a | b;
         3'b010: r = (longint'(a) + longint'(b)) % (64'd1 << 32);
         3'b110: r = (longint'(a) + (64'd1 << 32) - longint'(b)) % (64'd1 << 32);
         3'b111: r = (int'(a) < int'(b)) ? 1 : 0;
         default: return {1'b1, 1'b1, 32'd0};
      endcase
      return {1'b0, (r == 0), r[31:0]};
   endfunction

   function automatic bit legal(input logic [2:0] op);
      return !(op == 3'b011 || op == 3'b100 || op == 3'b101);
   endfunction

   task automatic step(); @(posedge clk); #1; endtask

   // One full transaction starting in IDLE just after a clock edge.
   // bp = number of RESP cycles with rsp_ready low; drop = release valids.
   task automatic run_txn(input bit v0, v1,
                          input logic [31:0] a0, b0, input logic [2:0] op0,
                          input logic [31:0] a1, b1, input logic [2:0] op1,
                          input int bp, input bit drop);
      bit g;
      logic [31:0] ea, eb, hold;
      logic [2:0] eop;
      logic [33:0] e;
      req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
      req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
      rsp_ready  = 1'b0;
      g   = (v0 && v1) ? exp_prio : v1;
      ea  = g ? a1 : a0;
      eb  = g ? b1 : b0;
      eop = g ? op1 : op0;
      e   = model(ea, eb, eop);
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_rsp_valid", rsp_valid, 0);
      chk("ready0", req0_ready, v0 && !g);
      chk("ready1", req1_ready, v1 && g);
      step();
      if (drop) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      req0_a = $urandom; req0_b = $urandom; req0_op = 3'($urandom);
      req1_a = $urandom; req1_b = $urandom; req1_op = 3'($urandom);
      @(negedge clk);
      chk("exec_busy", busy, 1);
      chk("exec_rsp_valid", rsp_valid, 0);
      chk("exec_readies", {req0_ready, req1_ready}, 0);
      chk("alu_a", alu_a, ea);
      chk("alu_b", alu_b, eb);
      chk("alu_control", alu_control, legal(eop) ? eop : 3'b010);
      step();
      rsp_ready = (bp == 0);
      @(negedge clk);
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_id", rsp_id, g);
      chk("rsp_result", rsp_result, e[31:0]);
      chk("rsp_zero", rsp_zero, e[32]);
      chk("rsp_err", rsp_err, e[33]);
      chk("resp_readies", {req0_ready, req1_ready}, 0);
      hold = rsp_result;
      for (int i = 1; i <= bp; i++) begin
         step();
         rsp_ready = (i == bp);
         req0_a = $urandom; req1_b = $urandom;
         @(negedge clk);
         chk("bp_rsp_valid", rsp_valid, 1);
         chk("bp_rsp_result", rsp_result, hold);
         chk("bp_rsp_id", rsp_id, g);
         chk("bp_readies", {req0_ready, req1_ready}, 0);
         chk("bp_alu_a", alu_a, ea);
      end
      step();
      rsp_ready = 1'b0;
      exp_prio = ~g;
   endtask

   logic [2:0] ops [8] = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111, 3'b011, 3'b100, 3'b101};

   initial begin
      reset = 1'b1; rsp_ready = 1'b0;
      req0_valid = 0; req1_valid = 0;
      req0_a = 0; req0_b = 0; req0_op = 0; req1_a = 0; req1_b = 0; req1_op = 0;
      exp_prio = 1'b0;
      repeat (2) step();
      reset = 1'b0;
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_readies", {req0_ready, req1_ready}, 0);
      chk("rst_alu_control", alu_control, 3'b010);
      chk("rst_alu_a", alu_a, 0);
      chk("rst_rsp", {rsp_result, rsp_zero, rsp_err, rsp_id}, 0);
      step();

      // Single add, sub to zero, illegal op.
      run_txn(1, 0, 5, 7, 3'b010, 0, 0, 0, 0, 1);
      run_txn(0, 1, 0, 0, 0, 9, 9, 3'b110, 0, 1);
      run_txn(1, 0, 3, 4, 3'b011, 0, 0, 0, 0, 1);

      // Contention: alternating grants, both valid held.
      for (int i = 0; i < 4; i++)
         run_txn(1, 1, 32'(i + 1), 32'd10, 3'b010, 32'd100, 32'(i), 3'b110, 0, 0);

      // Backpressure for 5 cycles.
      run_txn(1, 1, 32'hF0F0, 32'h0FF0, 3'b000, 32'h1234, 32'h4321, 3'b001, 5, 1);

      // slt with signed operands.
      run_txn(1, 0, 32'hFFFF_FFFF, 32'd1, 3'b111, 0, 0, 0, 0, 1);

      // Reset during EXEC discards the operation and restores req0 priority.
      run_txn(1, 0, 1, 1, 3'b010, 0, 0, 0, 0, 1);   // exp_prio now 1
      req1_valid = 1; req1_a = 8; req1_b = 8; req1_op = 3'b010;
      step();
      req1_valid = 0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("rx_busy", busy, 0);
      chk("rx_rsp_valid", rsp_valid, 0);
      chk("rx_alu_control", alu_control, 3'b010);
      chk("rx_rsp_result", rsp_result, 0);
      step();
      @(negedge clk);
      chk("rx_quiet_rsp_valid", rsp_valid, 0);
      step();
      exp_prio = 1'b0;
      run_txn(1, 1, 2, 3, 3'b010, 4, 5, 3'b010, 0, 1);

      // Randomized traffic.
      for (int i = 0; i < 40; i++) begin
         bit v0, v1;
         v0 = 1'($urandom); v1 = 1'($urandom);
         if (!v0 && !v1) v0 = 1'b1;
         run_txn(v0, v1, $urandom, $urandom, ops[$urandom_range(0, 7)],
                 $urandom, $urandom, ops[$urandom_range(0, 7)],
                 $urandom_range(0, 3), 1'($urandom));
      end

      req0_valid = 0; req1_valid = 0;
      @(negedge clk);
      chk("final_busy", busy, 0);
      chk("final_rsp_valid", rsp_valid, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req0_valid / req1_valid  in  1  requester i presents an operation.
REQ-005 req0_ready / req1_ready  out  1  arbiter accepts requester i's operation this cycle.
REQ-006 req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands of requester i.
REQ-007 req0_op / req1_op  in  3  ALU control code: 000 and, 001 or, 010 add, 110 sub, 111 slt.
REQ-008 alu_a, alu_b  out  WIDTH  operands to the shared combinational ALU.
REQ-009 alu_control  out  3  control code to the shared ALU.
REQ-010 alu_result  in  WIDTH  ALU result, valid within the same cycle.
REQ-011 alu_zero  in  1  ALU zero flag.
REQ-012 rsp_valid  out  1  response available.
REQ-013 rsp_ready  in  1  consumer takes the response.
REQ-014 rsp_id  out  1  requester index (0/1) owning the response.
REQ-015 rsp_result  out  WIDTH  captured result.
REQ-016 rsp_zero  out  1  captured zero flag.
REQ-017 rsp_err  out  1  operation code was illegal.
REQ-018 busy  out  1  high in any state other than IDLE.

Function
REQ-019 FSM states SHALL be IDLE, EXEC and RESP.
REQ-020 IDLE: if any req valid, grant exactly one; granted reqN_ready SHALL be 1 combinationally that cycle only; all readies SHALL be 0 outside IDLE.
REQ-021 Arbitration: both valid -> grant the requester not granted last; one valid -> grant it regardless of pointer; after reset requester 0 has priority.
REQ-022 On acceptance (valid && ready), a, b, op and id SHALL be latched into operand registers; state -> EXEC.
REQ-023 alu_a, alu_b and alu_control SHALL be driven from the operand registers at all times; they change only on acceptance or reset.
REQ-024 EXEC lasts exactly one cycle; at its end alu_result and alu_zero SHALL be captured into rsp_result and rsp_zero; state -> RESP.
REQ-025 Illegal op (011, 100, 101): alu_control SHALL be driven 010; capture SHALL force rsp_result = 0, rsp_zero = 1 and rsp_err = 1; legal ops capture rsp_err = 0.
REQ-026 RESP: rsp_valid = 1; rsp_id, rsp_result, rsp_zero and rsp_err SHALL be held stable until rsp_valid && rsp_ready.
REQ-027 On the response handshake, the last-grant pointer SHALL update to rsp_id and state -> IDLE; a new acceptance is possible the cycle after.
REQ-028 Latency: acceptance in cycle N -> rsp_valid in cycle N+2; with rsp_ready held high, one operation completes every 3 cycles.
REQ-029 Backpressure: while rsp_ready = 0 in RESP, no request SHALL be accepted and no output register SHALL change.
REQ-030 Request inputs that change while not accepted SHALL have no effect; a deasserted valid SHALL never be granted.

Reset
REQ-031 While reset = 1 at a clock edge: state -> IDLE, pointer -> requester 0 priority, operand registers -> 0, alu_control -> 010, rsp_result -> 0, rsp_zero/rsp_err/rsp_id -> 0.
REQ-032 Reset asserted in EXEC or RESP SHALL discard the in-flight operation; no response is produced for it.
REQ-033 After reset, rsp_valid, busy and both readies SHALL be 0 until a request is presented in IDLE.

Verification
REQ-034 Single add: req0 valid, a=5, b=7, op=010, rsp_ready=1 -> req0_ready at N; rsp_valid at N+2, rsp_id=0, rsp_result=12, rsp_zero=0, rsp_err=0.
REQ-035 Sub to zero: req1 a=9, b=9, op=110 -> rsp_result=0, rsp_zero=1, rsp_id=1.
REQ-036 Contention: both valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1; each response carries the matching id and result.
REQ-037 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_result stable, both readies 0; completes on the first cycle rsp_ready=1.
REQ-038 Illegal op 011 with a=3, b=4 -> alu_control=010, rsp_err=1, rsp_result=0, rsp_zero=1.
REQ-039 Reset in EXEC -> next cycle busy=0, rsp_valid=0, no response; next request is served with requester 0 priority.
